// File: rtl/prog_loader_pkg.sv
// Shared definitions for the program-memory loader: window bounds, frame
// header byte, loader state encoding and the frame end-address helper.
package prog_loader_pkg;

    localparam logic [15:0] PROG_BOUND_L = 16'hC000;
    localparam logic [15:0] PROG_BOUND_U = 16'hFFFF;
    localparam logic [7:0]  LOADER_HDR   = 8'hA5;

    typedef enum logic [3:0] {
        ST_IDLE,
        ST_A_LO,
        ST_A_HI,
        ST_C_LO,
        ST_C_HI,
        ST_CHK,
        ST_DATA,
        ST_CSUM,
        ST_FIN
    } ld_state_e;

    // Last byte address touched by a frame, kept in 17 bits so a wrap past
    // 16'hFFFF shows up in bit 16.
    function automatic logic [16:0] frame_end(input logic [15:0] addr, input logic [15:0] cnt);
        return {1'b0, addr} + {1'b0, cnt} - 17'd1;
    endfunction

endpackage

// File: rtl/prog_loader_frame_chk.sv
// Frame checker: running XOR checksum register and combinational
// program-window bounds check on the latched address/count.
module prog_loader_frame_chk
    import prog_loader_pkg::*;
#(
    parameter logic [15:0] BOUND_L = PROG_BOUND_L,
    parameter logic [15:0] BOUND_U = PROG_BOUND_U
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        acc_clr_i,
    input  logic        acc_en_i,
    input  logic [7:0]  byte_i,
    input  logic [15:0] addr_i,
    input  logic [15:0] cnt_i,
    output logic [7:0]  acc_o,
    output logic        bad_o
);

    logic [7:0]  acc_q, acc_d;
    logic [16:0] end_w;

    // Next accumulator value: clear at frame start, fold in each covered byte.
    always_comb begin
        acc_d = acc_q;
        if (acc_clr_i)
            acc_d = 8'h00;
        else if (acc_en_i)
            acc_d = acc_q ^ byte_i;
    end

    // Accumulator register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            acc_q <= 8'h00;
        else
            acc_q <= acc_d;
    end

    assign end_w = frame_end(addr_i, cnt_i);
    assign acc_o = acc_q;
    assign bad_o = (addr_i < BOUND_L)
                || ((cnt_i != 16'd0) && (end_w > {1'b0, BOUND_U}))
                || end_w[16];

endmodule

// File: rtl/prog_loader.sv
// Byte-serial program loader: parses HDR/addr/count/data/checksum frames from
// a valid/ready byte stream, issues byte writes into the program window one
// cycle after each data byte is accepted, and holds the CPU during a load.
module prog_loader
    import prog_loader_pkg::*;
#(
    parameter logic [15:0] BOUND_U       = PROG_BOUND_U,
    parameter logic [15:0] BOUND_L       = PROG_BOUND_L,
    parameter logic [7:0]  HDR           = LOADER_HDR,
    parameter bit          HOLD_AT_RESET = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  in_data,
    input  logic        in_valid,
    output logic        in_ready,
    output logic        mem_we,
    output logic [15:0] mem_addr,
    output logic [7:0]  mem_wdata,
    output logic        busy,
    output logic        done,
    output logic        err,
    output logic        cpu_hold
);

    ld_state_e   state_q, state_d;
    logic [15:0] addr_q, addr_d;     // frame address, then write pointer
    logic [15:0] cnt_q, cnt_d;       // frame count, then bytes remaining
    logic        we_q, we_d;
    logic [15:0] waddr_q, waddr_d;
    logic [7:0]  wdata_q, wdata_d;
    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        err_q, err_d;
    logic        hold_q, hold_d;
    logic        acc_clr, acc_en, bad;
    logic [7:0]  acc;
    logic        accept;

    assign in_ready = (state_q != ST_CHK) && (state_q != ST_FIN);
    assign accept   = in_valid && in_ready;

    prog_loader_frame_chk #(
        .BOUND_L (BOUND_L),
        .BOUND_U (BOUND_U)
    ) u_chk (
        .clk       (clk),
        .rst_n     (rst_n),
        .acc_clr_i (acc_clr),
        .acc_en_i  (acc_en),
        .byte_i    (in_data),
        .addr_i    (addr_q),
        .cnt_i     (cnt_q),
        .acc_o     (acc),
        .bad_o     (bad)
    );

    // Next-state, field latching, write pipeline and status flags.
    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        we_d    = 1'b0;
        waddr_d = waddr_q;
        wdata_d = wdata_q;
        busy_d  = busy_q;
        done_d  = done_q;
        err_d   = err_q;
        hold_d  = hold_q;
        acc_clr = 1'b0;
        acc_en  = 1'b0;
        unique case (state_q)
            ST_IDLE: if (accept && (in_data == HDR)) begin
                state_d = ST_A_LO;
                done_d  = 1'b0;
                err_d   = 1'b0;
                busy_d  = 1'b1;
                hold_d  = 1'b1;
                acc_clr = 1'b1;
            end
            ST_A_LO: if (accept) begin
                addr_d[7:0] = in_data;
                acc_en      = 1'b1;
                state_d     = ST_A_HI;
            end
            ST_A_HI: if (accept) begin
                addr_d[15:8] = in_data;
                acc_en       = 1'b1;
                state_d      = ST_C_LO;
            end
            ST_C_LO: if (accept) begin
                cnt_d[7:0] = in_data;
                acc_en     = 1'b1;
                state_d    = ST_C_HI;
            end
            ST_C_HI: if (accept) begin
                cnt_d[15:8] = in_data;
                acc_en      = 1'b1;
                state_d     = ST_CHK;
            end
            ST_CHK: begin
                if (bad) begin
                    err_d   = 1'b1;
                    busy_d  = 1'b0;
                    state_d = ST_IDLE;
                end else if (cnt_q == 16'd0) begin
                    state_d = ST_CSUM;
                end else begin
                    state_d = ST_DATA;
                end
            end
            ST_DATA: if (accept) begin
                we_d    = 1'b1;
                waddr_d = addr_q;
                wdata_d = in_data;
                addr_d  = addr_q + 16'd1;
                cnt_d   = cnt_q - 16'd1;
                acc_en  = 1'b1;
                if (cnt_q == 16'd1)
                    state_d = ST_CSUM;
            end
            ST_CSUM: if (accept) begin
                if (in_data == acc)
                    done_d = 1'b1;
                else
                    err_d = 1'b1;
                state_d = ST_FIN;
            end
            ST_FIN: begin
                busy_d  = 1'b0;
                if (done_q)
                    hold_d = 1'b0;
                state_d = ST_IDLE;
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset aborts any frame and drops a pending write.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            addr_q  <= 16'h0000;
            cnt_q   <= 16'h0000;
            we_q    <= 1'b0;
            waddr_q <= 16'h0000;
            wdata_q <= 8'h00;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            hold_q  <= HOLD_AT_RESET;
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            we_q    <= we_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            hold_q  <= hold_d;
        end
    end

    assign mem_we    = we_q;
    assign mem_addr  = waddr_q;
    assign mem_wdata = wdata_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign cpu_hold  = hold_q;

endmodule
